uart_ram_bridge: RTL
====================

UART_RAM_BRIDGE -- requirements
Module: uart_ram_bridge

Interface
REQ-001 Parameter ADDR_W, default 18, SRAM address width.
REQ-002 Parameter BURST, default 4, bytes per transaction, legal 1..16.
REQ-003 Parameter INC, default 8'h01, value added to each byte on readback.
REQ-004 CLK  input  1  system clock; reset RST, asynchronous, active-low; clock CLK.
REQ-005 RST  input  1  asynchronous active-low reset.
REQ-006 base_addr  input  ADDR_W  SRAM base address, sampled on leaving IDLE.
REQ-007 data_ready  input  1  UART receive byte available.
REQ-008 tbre, tsre  input  1 each  UART transmit buffer empty / transmit shift register empty.
REQ-009 rdn, wrn  output  1 each  UART read/write strobes, active-low.
REQ-010 ram_addr  output  ADDR_W  SRAM address.
REQ-011 ram_data  inout  16  shared SRAM/UART data bus.
REQ-012 ram_oe, ram_we, ram_en  output  1 each  SRAM strobes, active-low.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 state  output  4  current state encoding, debug.
REQ-015 led  output  8  last byte transmitted.

Function
REQ-016 States: IDLE, RX_WAIT, RX_RD, RX_CAP, WR_SETUP, WR_PULSE, WR_HOLD, RD_SETUP, RD_CAP, TX_DRIVE, TX_REL, TX_TBRE, TX_TSRE.
REQ-017 IDLE -> RX_WAIT next cycle unconditionally; index cleared; base_addr latched.
REQ-018 RX_WAIT: rdn=1; stay until data_ready=1, then RX_RD.
REQ-019 RX_RD: rdn=0 one cycle; RX_CAP: rdn=0, ram_data[7:0] captured into buffer[index] at end of cycle.
REQ-020 After RX_CAP: index+1; if index reaches BURST, index cleared and go WR_SETUP, else RX_WAIT.
REQ-021 Write phase per byte: WR_SETUP drives ram_addr, ram_data={8'h00,buffer[index]}, ram_en=0; WR_PULSE ram_we=0; WR_HOLD ram_we=1 with data still driven; 3 cycles/byte.
REQ-022 After last WR_HOLD index cleared, go RD_SETUP; ram_data released to Z.
REQ-023 Read phase per byte: RD_SETUP ram_en=0, ram_oe=0; RD_CAP captures ram_data[7:0] as tx byte, ram_oe=1.
REQ-024 TX_DRIVE: ram_data driven with tx byte, wrn=0; TX_REL: wrn=1, led updated; TX_TBRE waits tbre=1; TX_TSRE waits tsre=1.
REQ-025 After TX_TSRE: index+1; if index reaches BURST go IDLE, else RD_SETUP.
REQ-026 ram_addr = (base_addr + index) mod 2^ADDR_W; wrap at top of address space is silent.
REQ-027 Arithmetic 8-bit modulo 256; 8'hFF+1 = 8'h00.
REQ-028 ram_data driven only in WR_SETUP, WR_PULSE, WR_HOLD, TX_DRIVE, TX_REL; Z otherwise; never driven while ram_oe=0 or rdn=0.
REQ-029 rdn and ram_oe never low in the same cycle; ram_we and wrn never low in the same cycle.
REQ-030 ram_en high in all RX_* and TX_* states.
REQ-031 base_addr changes while busy have no effect until next IDLE.
REQ-032 data_ready ignored outside RX_WAIT.
REQ-033 All outputs registered; state output equals current state register.

Reset
REQ-034 RST low: state IDLE, index 0, rdn=wrn=ram_oe=ram_we=ram_en=1, ram_data Z, ram_addr 0, led 0, busy 0.
REQ-035 RST asserted mid-operation aborts immediately; buffer contents undefined; restart from IDLE after release.

Configuration
REQ-036 Macro UART_RAM_BRIDGE_INC_EN defined: tx byte = SRAM byte + INC.
REQ-037 Macro UART_RAM_BRIDGE_INC_EN undefined: tx byte = SRAM byte unchanged; INC unused.

Verification
REQ-038 BURST=4, base 18'h00100, rx 11,22,33,44 -> SRAM 0x100..0x103 = 0011,0022,0033,0044; tx 12,23,34,45 (macro on).
REQ-039 Same stimulus, macro off -> tx 11,22,33,44; led=8'h44 at end.
REQ-040 Rx 8'hFF, BURST=1 -> tx 8'h00 (macro on).
REQ-041 base 18'h3FFFE, BURST=4 -> addresses 3FFFE,3FFFF,00000,00001.
REQ-042 tbre held 0 for 20 cycles -> state stays TX_TBRE, wrn=1, bus Z; resumes when tbre=1.
REQ-043 RST pulsed during WR_PULSE -> same cycle ram_we=1, ram_data Z, state IDLE.

Source files
------------

// File: rtl/uart_ram_bridge.sv
// uart_ram_bridge: collects BURST bytes from a UART, writes them to
// consecutive SRAM words starting at base_addr, reads them back and
// retransmits each one through the UART. The UART and the SRAM share the
// 16-bit ram_data bus.
// Build option: define UART_RAM_BRIDGE_INC_EN to add INC to every byte
// before it is retransmitted. When the macro is undefined, bytes are
// retransmitted unchanged.
`timescale 1ns/1ps

module uart_ram_bridge #(
   parameter int         ADDR_W = 18,
   parameter int         BURST  = 4,
   parameter logic [7:0] INC    = 8'h01
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              data_ready,
   input  logic              tbre,
   input  logic              tsre,
   output logic              rdn,
   output logic              wrn,
   output logic [ADDR_W-1:0] ram_addr,
   inout  wire  [15:0]       ram_data,
   output logic              ram_oe,
   output logic              ram_we,
   output logic              ram_en,
   output logic              busy,
   output logic [3:0]        state,
   output logic [7:0]        led
);

   localparam int IDX_W = (BURST > 1) ? $clog2(BURST) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST - 1);

`ifdef UART_RAM_BRIDGE_INC_EN
   localparam bit INC_EN = 1'b1;
`else
   localparam bit INC_EN = 1'b0;
`endif
   localparam logic [7:0] TX_ADD = INC_EN ? INC : 8'h00;

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      RX_WAIT  = 4'd1,
      RX_RD    = 4'd2,
      RX_CAP   = 4'd3,
      WR_SETUP = 4'd4,
      WR_PULSE = 4'd5,
      WR_HOLD  = 4'd6,
      RD_SETUP = 4'd7,
      RD_CAP   = 4'd8,
      TX_DRIVE = 4'd9,
      TX_REL   = 4'd10,
      TX_TBRE  = 4'd11,
      TX_TSRE  = 4'd12
   } state_t;

   state_t              r_state, w_next;
   logic [IDX_W-1:0]    r_idx, w_idx_next;
   logic [ADDR_W-1:0]   r_base, w_base_next;
   logic [ADDR_W-1:0]   r_addr, w_addr;
   logic [7:0]          r_buf [BURST];
   logic [7:0]          r_tx, r_led;
   logic [15:0]         r_dout, w_dout;
   logic                r_drive, w_drive;
   logic                r_rdn, r_wrn, r_oe, r_we, r_en, r_busy;
   logic                w_rdn, w_wrn, w_oe, w_we, w_en, w_busy;
   logic                w_last;
   logic [7:0]          w_tx_byte;

   assign w_last    = (r_idx == LAST_IDX);
   assign w_tx_byte = ram_data[7:0] + TX_ADD;

   // Next-state, index and base-address selection.
   // NOTE: every always_comb output gets a default first, so no path through the case can infer a latch.
   always_comb begin
      w_next      = r_state;
      w_idx_next  = r_idx;
      w_base_next = r_base;
      case (r_state)
         IDLE: begin
            w_next      = RX_WAIT;
            w_idx_next  = '0;
            w_base_next = base_addr;
         end
         RX_WAIT:  if (data_ready) w_next = RX_RD;
         RX_RD:    w_next = RX_CAP;
         RX_CAP: begin
            if (w_last) begin
               w_idx_next = '0;
               w_next     = WR_SETUP;
            end else begin
               w_idx_next = r_idx + 1'b1;
               w_next     = RX_WAIT;
            end
         end
         WR_SETUP: w_next = WR_PULSE;
         WR_PULSE: w_next = WR_HOLD;
         WR_HOLD: begin
            if (w_last) begin
               w_idx_next = '0;
               w_next     = RD_SETUP;
            end else begin
               w_idx_next = r_idx + 1'b1;
               w_next     = WR_SETUP;
            end
         end
         RD_SETUP: w_next = RD_CAP;
         RD_CAP:   w_next = TX_DRIVE;
         TX_DRIVE: w_next = TX_REL;
         TX_REL:   w_next = TX_TBRE;
         TX_TBRE:  if (tbre) w_next = TX_TSRE;
         TX_TSRE: begin
            if (tsre) begin
               if (w_last) begin
                  w_idx_next = '0;
                  w_next     = IDLE;
               end else begin
                  w_idx_next = r_idx + 1'b1;
                  w_next     = RD_SETUP;
               end
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // Output values decoded from the state being entered, so the registered outputs line up with r_state.
   always_comb begin
      w_rdn   = !(w_next inside {RX_RD, RX_CAP});
      w_wrn   = (w_next != TX_DRIVE);
      w_oe    = (w_next != RD_SETUP);
      w_we    = (w_next != WR_PULSE);
      w_en    = !(w_next inside {WR_SETUP, WR_PULSE, WR_HOLD, RD_SETUP, RD_CAP});
      w_drive = w_next inside {WR_SETUP, WR_PULSE, WR_HOLD, TX_DRIVE, TX_REL};
      w_busy  = (w_next != IDLE);
      w_addr  = w_base_next + ADDR_W'(w_idx_next);
      w_dout  = r_dout;
      if (w_next inside {WR_SETUP, WR_PULSE, WR_HOLD})
         w_dout = {8'h00, r_buf[w_idx_next]};
      else if (w_next == TX_DRIVE)
         w_dout = {8'h00, w_tx_byte};
   end

   // State, index and all registered outputs; async reset returns everything to the idle/released condition.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_base  <= '0;
         r_addr  <= '0;
         r_rdn   <= 1'b1;
         r_wrn   <= 1'b1;
         r_oe    <= 1'b1;
         r_we    <= 1'b1;
         r_en    <= 1'b1;
         r_busy  <= 1'b0;
         r_drive <= 1'b0;
         r_dout  <= '0;
         r_tx    <= '0;
         r_led   <= '0;
      end else begin
         r_state <= w_next;
         r_idx   <= w_idx_next;
         r_base  <= w_base_next;
         r_addr  <= w_addr;
         r_rdn   <= w_rdn;
         r_wrn   <= w_wrn;
         r_oe    <= w_oe;
         r_we    <= w_we;
         r_en    <= w_en;
         r_busy  <= w_busy;
         r_drive <= w_drive;
         r_dout  <= w_dout;
         if (r_state == RD_CAP) r_tx <= w_tx_byte;
         if (w_next == TX_REL)  r_led <= r_tx;
      end
   end

   // Receive buffer: the byte on the bus is stored at the end of RX_CAP.
   // NOTE: the buffer is deliberately not reset; it is always written before it is read.
   always_ff @(posedge CLK) begin
      if (r_state == RX_CAP) r_buf[r_idx] <= ram_data[7:0];
   end

   assign ram_data = r_drive ? r_dout : 16'hzzzz;
   assign rdn      = r_rdn;
   assign wrn      = r_wrn;
   assign ram_oe   = r_oe;
   assign ram_we   = r_we;
   assign ram_en   = r_en;
   assign ram_addr = r_addr;
   assign busy     = r_busy;
   assign state    = r_state;
   assign led      = r_led;

endmodule
